display_scan: RTL
=================

# display_scan

Time-multiplexed driver for the three-digit seven-segment display, directly downstream of the frequency-to-segment decoder. Takes the decoder's three 8-bit active-low segment codes (units, tens, hundreds), shows them one digit at a time on a shared segment bus with one anode strobe per digit, and inserts a blank gap between digits to suppress ghosting. All three codes are latched together once per scan frame, so a frame never mixes digits from two different inputs.

## Interface
- DIV, 50000: cycles each digit is lit (1 ms at 50 MHz); legal range ≥1.
- GAP, 500: blank cycles between digits; legal range ≥1.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- En  in  1  display enable; 0 forces outputs dark, with no effect on the scan state.
- Display_U  in  8  units code, active-low, bit7 = DP, bits6..0 = g..a.
- Display_D  in  8  tens code, same format.
- Display_C  in  8  hundreds code, same format.
- Seg  out  8  shared segment bus, active-low, registered.
- An  out  3  anode strobes, active-low, registered; bit0 = units, bit1 = tens, bit2 = hundreds.
- Frame_Tick  out  1  one-cycle pulse at the start of each scan frame, registered.

## Operation
- State machine with two states. SHOW drives one digit. GAP drives all digits dark.
- Counter cnt: width = ceil(log2(max(DIV,GAP)))+1. Cleared on every state change.
- Digit index idx cycles 0 (U) → 1 (D) → 2 (C) → 0.
- SHOW:
  - An = ~(1<<idx) and Seg = lat[idx].
  - When cnt == DIV-1, move to GAP.
- GAP:
  - An = 3'b111 and Seg = 8'hFF.
  - When cnt == GAP-1, advance idx and move to SHOW.
  - If idx goes 2→0 on that edge, also latch Display_U/D/C into lat[0..2] and set Frame_Tick = 1 for the next cycle.
- Input changes outside the latch edge have no effect until the next frame.
- En = 0: An = 3'b111 and Seg = 8'hFF. The state, cnt, idx, latching and Frame_Tick continue unchanged. When En rises, the display resumes in the current slot on the next edge.
- Reset: state = GAP, idx = 2, cnt = 0, lat[0..2] = 8'hFF, Seg = 8'hFF, An = 3'b111, Frame_Tick = 0.
- Reset asserted mid-frame: all of the above reset values are forced on the next edge, overriding any transition that would occur on that edge.

## Timing
- Outputs are registered. They change on the same edge as the state transition that causes them.
- Frame period = 3·(DIV+GAP) cycles. Each digit is lit for exactly DIV cycles, and each gap lasts exactly GAP cycles.
- First frame after reset release:
  - Dark for GAP cycles.
  - On the edge ending that gap, An becomes 3'b110 and Seg becomes the Display_U value sampled on that same edge.
  - Frame_Tick is high during that first lit cycle.
- Input-to-display latency: from the latch edge to the lit output of each digit. Units are shown at +0 cycles, tens at +(DIV+GAP), hundreds at +2·(DIV+GAP).
- No two An bits are ever low in the same cycle. There is at least one dark cycle between any two lit digits.

## Configuration
- LEADING_ZERO_BLANK_EN defined: blanking is decided at the latch edge.
  - If the latched C code equals 8'b11000000 (glyph 0), the hundreds slot stays dark (An bit2 = 1, Seg = 8'hFF) for its whole SHOW interval.
  - If C is blanked and D also equals 8'b11000000, the tens slot is dark as well.
  - The units digit is never blanked.
  - Slot timing and Frame_Tick are unchanged.
- Undefined: all three digits are always shown as latched.

## Test plan
- DIV=4, GAP=2; U=8'hF9, D=8'hA4, C=8'hB0; release reset at t0 → dark for 2 cycles, then:
  - 4 cycles An=110, Seg=F9;
  - 2 cycles dark;
  - 4 cycles An=101, Seg=A4;
  - 2 cycles dark;
  - 4 cycles An=011, Seg=B0.
  - Frame_Tick pulses every 18 cycles.
- Change U from F9 to 99 during the tens slot → units slot still shows F9 until the next frame, then shows 99.
- Set En=0 for 5 cycles mid-SHOW → An=111 and Seg=FF during those cycles. Frame_Tick spacing stays at 18 cycles.
- Assert rst for 1 cycle during the hundreds slot → next cycle Seg=FF, An=111, Frame_Tick=0. The next lit units slot starts exactly 2 cycles after reset release.
- LEADING_ZERO_BLANK_EN defined; U=F9, D=C0, C=C0 → only the units slot lights; tens and hundreds slots stay An=111. Undefined → all three light.
- Sample every cycle → never more than one An bit low, never a lit digit adjacent to another lit digit without a gap.

Source files
------------

// File: rtl/display_scan.sv
// Three-digit seven-segment scan driver: SHOW/GAP multiplexing with per-frame input latching.
// Optional leading-zero blanking of tens/hundreds is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan #(
  parameter int DIV = 50000,
  parameter int GAP = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       En,
  input  logic [7:0] Display_U,
  input  logic [7:0] Display_D,
  input  logic [7:0] Display_C,
  output logic [7:0] Seg,
  output logic [2:0] An,
  output logic       Frame_Tick
);

  localparam int MAXC = (DIV > GAP) ? DIV : GAP;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
  localparam logic [7:0]    GLYPH_0  = 8'b1100_0000;

  typedef enum logic {S_SHOW = 1'b0, S_GAP = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      lat_q [3];
  logic [7:0]      lat_d [3];
  logic [7:0]      seg_q, seg_d;
  logic [2:0]      an_q, an_d;
  logic            tick_q, tick_d;
  logic [2:0]      blank_s;
  logic [7:0]      code_s;

  // Slot sequencing; codes are latched only when the scan wraps back to units.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    lat_d   = lat_q;
    tick_d  = 1'b0;
    case (state_q)
      S_SHOW: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          state_d = S_SHOW;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_SHOW;
          cnt_d   = '0;
          if (idx_q == 2'd2) begin
            idx_d    = 2'd0;
            lat_d[0] = Display_U;
            lat_d[1] = Display_D;
            lat_d[2] = Display_C;
            tick_d   = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          state_d = S_GAP;
        end
      end
      default: begin
        state_d = S_GAP;
        cnt_d   = '0;
        idx_d   = 2'd2;
      end
    endcase
  end

  // Blanking follows the codes held for the frame, so it is fixed at the latch edge.
  always_comb begin
    blank_s = 3'b000;
`ifdef LEADING_ZERO_BLANK_EN
    blank_s[2] = (lat_d[2] == GLYPH_0);
    blank_s[1] = blank_s[2] && (lat_d[1] == GLYPH_0);
`else
    blank_s = 3'b000;
`endif
  end

  // Output decode from next state so outputs move on the same edge as the transition.
  always_comb begin
    seg_d  = 8'hFF;
    an_d   = 3'b111;
    code_s = 8'hFF;
    case (idx_d)
      2'd0:    code_s = lat_d[0];
      2'd1:    code_s = lat_d[1];
      2'd2:    code_s = lat_d[2];
      default: code_s = 8'hFF;
    endcase
    if (En && (state_d == S_SHOW) && !blank_s[idx_d]) begin
      an_d  = ~(3'b001 << idx_d);
      seg_d = code_s;
    end else begin
      an_d  = 3'b111;
      seg_d = 8'hFF;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_GAP;
      cnt_q   <= '0;
      idx_q   <= 2'd2;
      lat_q[0] <= 8'hFF;
      lat_q[1] <= 8'hFF;
      lat_q[2] <= 8'hFF;
      seg_q   <= 8'hFF;
      an_q    <= 3'b111;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
    end
  end

  assign Seg        = seg_q;
  assign An         = an_q;
  assign Frame_Tick = tick_q;

endmodule
